pcm_receiver: RTL and testbench
===============================

Name: pcm_receiver

Overview:
- Receive-side counterpart of the PCM audio sender.
- Takes the byte stream of a received Ethernet frame and extracts the little-endian signed 16-bit PCM payload into a two-bank (ping-pong) byte buffer.
- Plays the samples back one per audio-rate enable, as parallel PCM plus a first-order sigma-delta PDM bit for a 1-bit DAC pin.
- Sits between the Ethernet receive deframer and the audio output pin.

Parameters:
- PAYLOAD_OFS, 16: frame byte index (first byte after SFD = 0) of the first PCM byte.
- PAYLOAD_LEN, 494: payload length in bytes; must be even and ≤ 512.
- BANK_AW, 9: byte address width of one bank; buffer is 2^(BANK_AW+1) bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received frame byte
- rx_valid  in  1  rx_data valid this cycle
- rx_sof  in  1  accompanies first byte of a frame
- rx_eof  in  1  accompanies last byte of a frame
- rx_err  in  1  frame error (CRC/alignment), valid with rx_eof
- au_en_pcm  in  1  one-cycle sample-rate strobe, spacing ≥ 8 clk
- pcm  out  16  signed sample
- pcm_valid  out  1  one-cycle pulse when pcm updates
- pdm_en  in  1  PDM modulator clock enable
- pdm_out  out  1  sigma-delta bit
- underrun  out  1  one-cycle pulse: sample requested with no bank ready
- overrun  out  1  one-cycle pulse: good frame dropped because a bank is pending

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - pcm = 0, pcm_valid = 0, pdm_out = 0, underrun = 0, overrun = 0.
  - play_bank = 0, play_idx = 0, pending = 0, playing = 0, sigma-delta accumulator = 0, RX state = IDLE.
- Buffer: dual-port byte RAM. Write port is RX, read port is playback. Read latency is 1 clk. Bank select is the address MSB.
- RX writes only to bank wr_bank = !play_bank.

RX FSM: IDLE, HDR, PAY, WAIT_EOF, DROP
- rx_sof with rx_valid from any state: restart the byte counter at 0 and enter HDR.
- HDR: count bytes. At count == PAYLOAD_OFS, go to PAY and write that byte to offset 0.
- PAY: write byte k to wr_bank offset k. After PAYLOAD_LEN bytes, go to WAIT_EOF.
- WAIT_EOF: ignore trailing bytes until rx_eof.
- rx_eof handling:
  - Frame is good when rx_err = 0, state was WAIT_EOF (full payload received), and pending = 0. Then set pending = 1 and return to IDLE.
  - Frame is good but pending = 1: assert overrun for 1 clk and discard the frame.
  - rx_eof before the payload completes, or rx_err = 1: discard silently. pending is unchanged and wr_bank contents are don't-care.
- While pending = 1, a new frame's payload writes are suppressed (frame goes to DROP until eof), so the pending bank is never corrupted.

Playback, triggered by au_en_pcm:
- If playing = 0 and pending = 1: swap play_bank, clear pending, set playing = 1, play_idx = 0, then fetch.
- If playing = 0 and pending = 0: pcm = 0, pulse pcm_valid, pulse underrun.
- Fetch sequence:
  - Read low byte at 2·play_idx, then high byte at 2·play_idx+1.
  - pcm = {hi, lo}, with pcm_valid pulsed exactly 4 clk after au_en_pcm.
  - play_idx increments.
- When play_idx reaches PAYLOAD_LEN/2:
  - If pending = 1, swap banks seamlessly on the next strobe.
  - Otherwise set playing = 0. The next strobe gives an underrun and pcm = 0.
- An au_en_pcm arriving during an active fetch is ignored. The spec forbids this case.

Sigma-delta:
- 17-bit accumulator acc. On pdm_en: acc ← acc[15:0] + (pcm ^ 16'h8000), i.e. offset binary.
- pdm_out ← carry acc[16], registered.

Simultaneous events:
- A swap on au_en_pcm and a good rx_eof in the same clk: the swap consumes the old pending, and the new frame's bank was the old wr_bank. The new frame therefore sets pending only if the frame was written to the bank not now playing.
- Simplest compliant rule: an rx_eof coinciding with a swap is treated as overrun.
- Reset mid-frame or mid-fetch: everything returns to reset values immediately, and buffer contents are ignored.

Decomposition:
- Shared package/include holds:
  - PCM_W = 16.
  - RX state encodings.
  - Ethernet framing constants (header length 14, PAYLOAD_OFS default).
- Reuse the existing bram module for the 1024×8 buffer.
- Natural sub-module: pdm_modulator (accumulator and pdm_en). Everything else stays in pcm_receiver.

Test Plan:
- Good frame with payload bytes 0x34,0x12,0xCD,0xAB,… then 3 au_en_pcm strobes → pcm = 0x1234, then 0xABCD, each pcm_valid 4 clk after its strobe; no underrun.
- Strobe with no frame received → pcm = 0, pcm_valid and underrun pulse once.
- Frame with rx_err = 1 on eof, then strobe → underrun; pending stays 0.
- Two good frames back-to-back before any strobe → second frame gives an overrun pulse; playback outputs the first frame's samples.
- 247 samples played from frame A while frame B arrives → sample 248 is B[0] with no underrun; after B is exhausted with no frame C → underrun.
- pcm held at 0x4000 with pdm_en every clk → pdm_out density 75% ±1 over 256 clk. rst_n low mid-payload → all outputs 0 asynchronously, and the next frame is received correctly.

Source files
------------

// File: rtl/pcm_receiver_pkg.sv
// Shared constants and state encodings for the PCM receive path.
package pcm_receiver_pkg;

  localparam int PCM_W           = 16;
  localparam int ETH_HDR_LEN     = 14;
  // 14-byte MAC header followed by a 2-byte stream header before the samples
  localparam int PAYLOAD_OFS_DEF = ETH_HDR_LEN + 2;
  localparam int PAYLOAD_LEN_DEF = 494;
  localparam int BANK_AW_DEF     = 9;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_HDR,
    RX_PAY,
    RX_WAIT_EOF,
    RX_DROP
  } rx_state_e;

  typedef enum logic [1:0] {
    FT_IDLE,
    FT_LO,
    FT_HI,
    FT_OUT
  } fetch_state_e;

endpackage

// File: rtl/bram.sv
// Simple dual-port RAM: one synchronous write port, one read port with 1-clk latency.
module bram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array and read register are deliberately not reset; a reset
  // would stop this mapping onto block RAM, and contents are never trusted
  // until a complete frame has been written anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pcm_receiver_pdm.sv
// First-order sigma-delta modulator: the carry out of the phase accumulator is the PDM bit.
module pdm_modulator
  import pcm_receiver_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_en,
  input  logic [PCM_W-1:0] pcm,
  output logic             pdm_out
);

  localparam logic [PCM_W-1:0] SIGN = {1'b1, {(PCM_W-1){1'b0}}};

  logic [PCM_W:0] acc;
  logic [PCM_W:0] sum;

  // Flipping the sign bit turns two's complement into offset binary.
  always_comb sum = {1'b0, acc[PCM_W-1:0]} + {1'b0, pcm ^ SIGN};

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (pdm_en) acc <= sum;
  end

  assign pdm_out = acc[PCM_W];

endmodule

// File: rtl/pcm_receiver.sv
// Extracts PCM payload from received frames into a ping-pong buffer and plays it out per strobe.
module pcm_receiver
  import pcm_receiver_pkg::*;
#(
  parameter int PAYLOAD_OFS = PAYLOAD_OFS_DEF,
  parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEF,
  parameter int BANK_AW     = BANK_AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_sof,
  input  logic                    rx_eof,
  input  logic                    rx_err,
  input  logic                    au_en_pcm,
  output logic signed [PCM_W-1:0] pcm,
  output logic                    pcm_valid,
  input  logic                    pdm_en,
  output logic                    pdm_out,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int CNT_W = 16;
  localparam int IDX_W = BANK_AW - 1;
  localparam logic [CNT_W-1:0] OFS_C     = CNT_W'(PAYLOAD_OFS);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_LEN / 2 - 1);

  rx_state_e          rx_state, rx_next, eff_state;
  logic [CNT_W-1:0]   cnt, cnt_next, eff_cnt;
  logic               wr_en, set_pending, overrun_next, complete;
  logic [BANK_AW-1:0] wr_ofs;

  fetch_state_e       ft_state, ft_next;
  logic               ft_ur, pending, playing, play_bank;
  logic [IDX_W-1:0]   play_idx;
  logic [7:0]         lo_q, rd_data;
  logic               start, swap_now;
  logic [BANK_AW:0]   wr_addr, rd_addr;

  assign start    = au_en_pcm && (ft_state == FT_IDLE);
  assign swap_now = start && !playing && pending;

  assign wr_addr = {~play_bank, wr_ofs};
  assign rd_addr = {play_bank, play_idx, ft_state == FT_HI};

  bram #(.AW(BANK_AW + 1), .DW(8)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  pdm_modulator u_pdm (
    .clk     (clk),
    .rst_n   (rst_n),
    .pdm_en  (pdm_en),
    .pcm     (pcm),
    .pdm_out (pdm_out)
  );

  // A sof byte is handled as byte 0 of a fresh HDR pass, whatever state we were in.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rx_next      = rx_state;
    cnt_next     = cnt;
    eff_state    = rx_state;
    eff_cnt      = cnt;
    wr_en        = 1'b0;
    wr_ofs       = '0;
    set_pending  = 1'b0;
    overrun_next = 1'b0;
    complete     = 1'b0;
    if (rx_valid) begin
      if (rx_sof) begin
        eff_state = RX_HDR;
        eff_cnt   = '0;
        rx_next   = RX_HDR;
      end
      case (eff_state)
        RX_HDR: begin
          if (eff_cnt == OFS_C) begin
            if (pending) begin
              rx_next = RX_DROP;
            end else begin
              wr_en    = 1'b1;
              cnt_next = CNT_W'(1);
              rx_next  = RX_PAY;
            end
          end else begin
            cnt_next = eff_cnt + CNT_W'(1);
          end
        end
        RX_PAY: begin
          wr_en    = 1'b1;
          wr_ofs   = eff_cnt[BANK_AW-1:0];
          cnt_next = eff_cnt + CNT_W'(1);
          if (eff_cnt == LAST_BYTE) rx_next = RX_WAIT_EOF;
        end
        default: ;
      endcase
      if (rx_eof) begin
        complete = (eff_state == RX_WAIT_EOF) ||
                   (eff_state == RX_PAY && eff_cnt == LAST_BYTE);
        // A swap in this very cycle hands the write bank to playback, so the frame cannot be kept.
        if (!rx_err) begin
          if (complete && !pending && !swap_now) set_pending = 1'b1;
          else if (complete || eff_state == RX_DROP) overrun_next = 1'b1;
        end
        rx_next = RX_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_state <= rx_next;
      cnt      <= cnt_next;
      overrun  <= overrun_next;
      if (swap_now)         pending <= 1'b0;
      else if (set_pending) pending <= 1'b1;
    end
  end

  // Fetch: LO and HI each present one read address; the result lands 4 clk after the strobe.
  always_comb begin
    ft_next = ft_state;
    case (ft_state)
      FT_IDLE: if (au_en_pcm) ft_next = FT_LO;
      FT_LO:   ft_next = FT_HI;
      FT_HI:   ft_next = FT_OUT;
      FT_OUT:  ft_next = FT_IDLE;
      default: ft_next = FT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ft_state  <= FT_IDLE;
      ft_ur     <= 1'b0;
      play_bank <= 1'b0;
      play_idx  <= '0;
      playing   <= 1'b0;
      lo_q      <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      ft_state  <= ft_next;
      pcm_valid <= 1'b0;
      underrun  <= 1'b0;
      if (start) begin
        ft_ur <= !playing && !pending;
        if (swap_now) begin
          play_bank <= ~play_bank;
          playing   <= 1'b1;
          play_idx  <= '0;
        end
      end
      if (ft_state == FT_HI) lo_q <= rd_data;
      if (ft_state == FT_OUT) begin
        pcm_valid <= 1'b1;
        underrun  <= ft_ur;
        if (ft_ur) begin
          pcm <= '0;
        end else begin
          pcm      <= {rd_data, lo_q};
          play_idx <= play_idx + IDX_W'(1);
          if (play_idx == LAST_IDX) playing <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_receiver.sv
// Directed bench for pcm_receiver: frame reception, ping-pong playback, overrun/underrun, PDM density.
module tb_pcm_receiver;

  localparam int OFS = 16;
  localparam int LEN = 494;
  localparam int NS  = LEN / 2;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_err;
  logic        au_en_pcm, pdm_en;
  logic [15:0] pcm;
  logic        pcm_valid, pdm_out, underrun, overrun;

  int n_pass, n_total, ov_cnt, pv_cnt;

  pcm_receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_err    (rx_err),
    .au_en_pcm (au_en_pcm),
    .pcm       (pcm),
    .pcm_valid (pcm_valid),
    .pdm_en    (pdm_en),
    .pdm_out   (pdm_out),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun)   ov_cnt++;
    if (pcm_valid) pv_cnt++;
  end

  typedef enum {OP_STROBE, OP_SEND, OP_SEND_ERR, OP_SEND_SHORT, OP_RESET} op_e;
  typedef struct {
    op_e         op;
    int          id;
    logic [15:0] exp_pcm;
    logic        exp_ur;
    int          exp_ov;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [15:0] sample(input int id, input int k);
    if (id == 2 && k == 0) return 16'h1234;
    if (id == 2 && k == 1) return 16'hABCD;
    if (id == 6 && k == 0) return 16'h4000;
    return {8'(k) ^ 8'h5A, 8'(id)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // mode 0: full frame + 4 FCS bytes; 1: eof after half the payload; 2: stop mid-payload, no eof
  task automatic send_frame(input int id, input bit err, input int mode);
    int n_pay, total, p;
    logic [15:0] s;
    logic [7:0]  b;
    n_pay = (mode == 0) ? LEN : ((mode == 1) ? LEN / 2 : 100);
    total = OFS + n_pay + ((mode == 0) ? 4 : 0);
    for (int i = 0; i < total; i++) begin
      p = i - OFS;
      if (p < 0) begin
        b = 8'hA0 + 8'(i);
      end else if (p < n_pay) begin
        s = sample(id, p / 2);
        b = p[0] ? s[15:8] : s[7:0];
      end else begin
        b = 8'hEE;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      rx_sof   = (i == 0);
      rx_eof   = (mode != 2) && (i == total - 1);
      rx_err   = err && rx_eof;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      rx_err   = 1'b0;
      if (i % 50 == 7) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic strobe(input string nm, input logic [15:0] exp_pcm, input logic exp_ur);
    int lat, pv0;
    logic [15:0] got;
    logic got_ur;
    lat = 0; got = '0; got_ur = 1'b0; pv0 = pv_cnt;
    au_en_pcm = 1'b1;
    @(posedge clk); #1;
    au_en_pcm = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (pcm_valid && lat == 0) begin
        lat    = c;
        got    = pcm;
        got_ur = underrun;
      end
      if (c < 8) begin
        @(posedge clk); #1;
      end
    end
    check({nm, "_latency"}, lat, 4);
    check({nm, "_pcm"}, {16'h0, got}, {16'h0, exp_pcm});
    check({nm, "_underrun"}, {31'h0, got_ur}, {31'h0, exp_ur});
    check({nm, "_valid_pulses"}, pv_cnt - pv0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_pcm", {16'h0, pcm}, 0);
    check("rst_pcm_valid", {31'h0, pcm_valid}, 0);
    check("rst_pdm_out", {31'h0, pdm_out}, 0);
    check("rst_underrun", {31'h0, underrun}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ov0, ones;
    n_pass = 0; n_total = 0; ov_cnt = 0; pv_cnt = 0;
    rst_n = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    rx_err = 1'b0; au_en_pcm = 1'b0; pdm_en = 1'b0;

    vecs[0]  = '{OP_STROBE,     0, 16'h0000,       1'b1, 0};
    vecs[1]  = '{OP_SEND_ERR,   1, 16'h0000,       1'b0, 0};
    vecs[2]  = '{OP_STROBE,     0, 16'h0000,       1'b1, 0};
    vecs[3]  = '{OP_SEND,       2, 16'h0000,       1'b0, 0};
    vecs[4]  = '{OP_STROBE,     0, 16'h1234,       1'b0, 0};
    vecs[5]  = '{OP_STROBE,     0, 16'hABCD,       1'b0, 0};
    vecs[6]  = '{OP_STROBE,     0, sample(2, 2),   1'b0, 0};
    vecs[7]  = '{OP_RESET,      0, 16'h0000,       1'b0, 0};
    vecs[8]  = '{OP_SEND,       3, 16'h0000,       1'b0, 0};
    vecs[9]  = '{OP_SEND,       4, 16'h0000,       1'b0, 1};
    vecs[10] = '{OP_STROBE,     0, sample(3, 0),   1'b0, 0};
    vecs[11] = '{OP_STROBE,     0, sample(3, 1),   1'b0, 0};
    vecs[12] = '{OP_SEND_SHORT, 5, 16'h0000,       1'b0, 0};
    vecs[13] = '{OP_STROBE,     0, sample(3, 2),   1'b0, 0};

    #2;
    do_reset();

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_STROBE: strobe($sformatf("v%0d", i), vecs[i].exp_pcm, vecs[i].exp_ur);
        OP_RESET:  do_reset();
        default: begin
          ov0 = ov_cnt;
          send_frame(vecs[i].id, vecs[i].op == OP_SEND_ERR,
                     (vecs[i].op == OP_SEND_SHORT) ? 1 : 0);
          repeat (3) @(posedge clk);
          #1;
          check($sformatf("v%0d_overrun", i), ov_cnt - ov0, vecs[i].exp_ov);
        end
      endcase
    end

    // Frame B arrives while frame A plays; B[0] must follow A's last sample seamlessly.
    do_reset();
    send_frame(10, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    strobe("xa_0", sample(10, 0), 1'b0);
    fork
      send_frame(11, 1'b0, 0);
      for (int k = 1; k < NS; k++) strobe($sformatf("xa_%0d", k), sample(10, k), 1'b0);
    join
    for (int k = 0; k < NS; k++) strobe($sformatf("xb_%0d", k), sample(11, k), 1'b0);
    strobe("xb_exhausted", 16'h0000, 1'b1);

    // Sigma-delta density with pcm held at 0x4000 (offset value 0xC000 -> 75%).
    do_reset();
    send_frame(6, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    strobe("pdm_load", 16'h4000, 1'b0);
    ones = 0;
    pdm_en = 1'b1;
    repeat (256) begin
      @(posedge clk); #1;
      ones += int'(pdm_out);
    end
    check("pdm_density", (ones >= 191 && ones <= 193) ? 192 : ones, 192);
    for (int i = 0; i < 8 && !pdm_out; i++) begin
      @(posedge clk); #1;
    end
    pdm_en = 1'b0;
    check("pdm_high_before_reset", {31'h0, pdm_out}, 1);

    // Reset in the middle of a payload, then a clean frame must still be received.
    send_frame(7, 1'b0, 2);
    do_reset();
    send_frame(8, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    strobe("post_rst_0", sample(8, 0), 1'b0);
    strobe("post_rst_1", sample(8, 1), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
